// File: rtl/ac_motor_pwm_deadtime.sv
// -----------------------------------------------------------------------------
// ac_motor_pwm_deadtime
//
// Multi-channel carrier-compare PWM generator with dead-time insertion for
// half-bridge gate drivers. Each channel compares its sine reference against
// a shared triangle carrier. A per-channel FSM then drives the high-side and
// low-side gates. A break-before-make interval of `deadtime` clk cycles
// separates every change of conducting side.
//
// Ports
//   clk       : single clock, all state updates on the rising edge
//   reset_n   : asynchronous active-low reset
//   enable    : global run; low turns every channel off on the next edge
//   triangle  : signed carrier, WIDTH bits
//   sine      : packed signed references, channel i at [i*WIDTH +: WIDTH]
//   deadtime  : unsigned dead time in clk cycles, sampled on entry to DEAD
//   out_hi    : high-side gate per channel
//   out_lo    : low-side gate per channel
//   en        : driver enable per channel (low only while OFF)
// -----------------------------------------------------------------------------
module ac_motor_pwm_deadtime #(
   parameter int CHANNELS = 3,
   parameter int WIDTH    = 24,
   parameter int DT_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic signed [WIDTH-1:0]       triangle,
   input  logic [CHANNELS*WIDTH-1:0]     sine,
   input  logic [DT_WIDTH-1:0]           deadtime,
   output logic [CHANNELS-1:0]           out_hi,
   output logic [CHANNELS-1:0]           out_lo,
   output logic [CHANNELS-1:0]           en
);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_DEAD = 2'd1,
      ST_HIGH = 2'd2,
      ST_LOW  = 2'd3
   } state_e;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

      logic signed [WIDTH-1:0] ref_s;
      logic                    demand_d;
      logic                    demand_q;
      state_e                  state_d, state_q;
      logic [DT_WIDTH-1:0]     cnt_d, cnt_q;
      logic                    start_gap;
      state_e                  side_s;
      logic                    out_hi_q, out_lo_q, en_q;

      assign ref_s = $signed(sine[i*WIDTH +: WIDTH]);

      // Both operands are signed, so this is a two's-complement compare.
      // Equality falls to the low side.
      assign demand_d = (ref_s > triangle);

      // Side that the registered demand asks for.
      assign side_s = demand_q ? ST_HIGH : ST_LOW;

      // NOTE: every variable assigned in this block gets a default first, so no
      // path leaves a value unassigned and no latch is inferred.
      always_comb begin
         state_d   = state_q;
         cnt_d     = cnt_q;
         start_gap = 1'b0;

         if (!enable) begin
            state_d = ST_OFF;
            cnt_d   = '0;
         end else begin
            unique case (state_q)
               ST_OFF:  start_gap = 1'b1;
               ST_HIGH: start_gap = !demand_q;
               ST_LOW:  start_gap = demand_q;
               ST_DEAD: begin
                  // The counter only runs down. A demand change during the
                  // interval only chooses the side taken at exit.
                  if (cnt_q > DT_WIDTH'(1)) begin
                     cnt_d = cnt_q - DT_WIDTH'(1);
                  end else begin
                     state_d = side_s;
                     cnt_d   = '0;
                  end
               end
               default: begin
                  state_d = ST_OFF;
                  cnt_d   = '0;
               end
            endcase

            // The dead interval length is latched here only. With a zero dead
            // time the bridge swaps sides, or leaves OFF, in a single edge.
            if (start_gap) begin
               if (deadtime == '0) begin
                  state_d = side_s;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_DEAD;
                  cnt_d   = deadtime;
               end
            end
         end
      end

      // NOTE: the reset clears only control and status flops; there is no storage
      // array here that would need to stay out of the reset network.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            demand_q <= 1'b0;
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            out_hi_q <= 1'b0;
            out_lo_q <= 1'b0;
            en_q     <= 1'b0;
         end else begin
            // NOTE: non-blocking assignments let every flop sample the old value
            // of its source, so order in this block does not matter.
            demand_q <= demand_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            // The gate flops are decoded from the next state. This keeps the
            // pins glitch-free and aligned with the state register. Only one
            // of the two gates can be set for any single state value.
            out_hi_q <= (state_d == ST_HIGH);
            out_lo_q <= (state_d == ST_LOW);
            en_q     <= (state_d != ST_OFF);
         end
      end

      assign out_hi[i] = out_hi_q;
      assign out_lo[i] = out_lo_q;
      assign en[i]     = en_q;
   end

endmodule

// File: doc/ac_motor_pwm_deadtime.md
AC_MOTOR_PWM_DEADTIME -- requirements
Module: ac_motor_pwm_deadtime

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 3: number of independent half-bridge channels.
REQ-002 The block SHALL have parameter WIDTH, default 24: signed width of the carrier and each reference sample.
REQ-003 The block SHALL have parameter DT_WIDTH, default 8: width of the dead-time count.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port enable, input, 1 bit: global run; low forces every channel off.
REQ-007 The block SHALL have port triangle, input, WIDTH bits, signed: shared carrier.
REQ-008 The block SHALL have port sine, input, CHANNELS*WIDTH bits: packed signed references; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port deadtime, input, DT_WIDTH bits, unsigned: dead time in clk cycles.
REQ-010 The block SHALL have port out_hi, output, CHANNELS bits: high-side gate per channel.
REQ-011 The block SHALL have port out_lo, output, CHANNELS bits: low-side gate per channel.
REQ-012 The block SHALL have port en, output, CHANNELS bits: driver enable per channel.

Function
REQ-013 Each channel SHALL register demand_q[i] = (sine_i > triangle), signed compare at full WIDTH, one clk after sampling.
REQ-014 Each channel SHALL run an independent FSM with states OFF, DEAD, HIGH, LOW.
REQ-015 The outputs SHALL be registered: HIGH gives out_hi=1, out_lo=0; LOW gives out_hi=0, out_lo=1; OFF and DEAD give both 0.
REQ-016 en[i] SHALL be 0 in OFF and 1 in DEAD, HIGH and LOW.
REQ-017 From OFF with enable=1, the FSM SHALL enter DEAD with the counter loaded from deadtime.
REQ-018 From HIGH with demand_q=0, or from LOW with demand_q=1, the FSM SHALL enter DEAD with the counter loaded from deadtime.
REQ-019 The deadtime value SHALL be sampled only on entry to DEAD; later changes do not affect a dead interval already in progress.
REQ-020 In DEAD with count>1, the counter SHALL decrement; with count<=1, the FSM SHALL exit to HIGH if demand_q=1, else to LOW.
REQ-021 For deadtime=D>=1, both gates SHALL be low for exactly D cycles between opposite conductions.
REQ-022 For deadtime=0, the FSM SHALL swap HIGH<->LOW directly in one edge with no DEAD cycle, and OFF SHALL go directly to the demanded side.
REQ-023 Demand toggling during DEAD SHALL neither restart nor shorten the counter; the side taken at exit is the demand_q at the exit edge.
REQ-024 With enable=0, every channel SHALL go to OFF on the next edge from any state, with the counter cleared; this overrides REQ-017 to REQ-022.
REQ-025 out_hi[i] & out_lo[i] SHALL never be 1 in any cycle, including reset, enable edges and deadtime changes.
REQ-026 Latency from a carrier/reference crossing to the first gate change SHALL be 2 clk cycles: compare register, then FSM register.
REQ-027 sine == triangle SHALL give demand 0 (low side).

Reset
REQ-028 reset_n=0 SHALL immediately force out_hi=0, out_lo=0, en=0, demand_q=0, all FSMs to OFF and all counters to 0, independent of clk.
REQ-029 Reset deassertion mid-operation SHALL resume from OFF; the first conduction follows a full dead interval per REQ-017.

Verification
REQ-030 The bench SHALL cover enable rise, CHANNELS=3, D=4, sine0=+1000, triangle=0: out_hi[0]=0 for 4 cycles after en[0]=1, then 1; out_lo[0] stays 0.
REQ-031 The bench SHALL cover sine0 stepping from +1000 to -1000 with D=4: out_hi[0] falls 2 cycles after the step, both gates 0 for exactly 4 cycles, then out_lo[0]=1.
REQ-032 The bench SHALL cover D=0 with sine0 alternating sign every 10 cycles: direct swaps, no cycle with both gates 0 while en=1, never both 1.
REQ-033 The bench SHALL cover a demand toggle at cycle 2 of a D=6 dead interval and a deadtime write to 1 within that interval: the interval still lasts 6 cycles and exits to the demand current at exit.
REQ-034 The bench SHALL cover enable=0 while HIGH, then reset_n=0 asynchronously mid-DEAD: all outputs 0 on the next edge or immediately respectively; after release the channel returns via a full dead interval.
REQ-035 The bench SHALL drive triangle and three 120-degree sines for 2500 cycles while checking REQ-025 and per-channel pulse ordering.
